// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic with a stored-carry chain,
// a shift-add multiplier and bit-serial shifts behind a start/busy/done handshake.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_SHF} state_e;

  typedef enum logic [3:0] {
    OP_NOTA = 4'd0,  OP_NOTB = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_XNOR = 4'd5,  OP_ADD = 4'd6,  OP_SUB  = 4'd7,
    OP_ADC  = 4'd8,  OP_SBC  = 4'd9,  OP_MUL = 4'd10, OP_LSL  = 4'd11,
    OP_LSR  = 4'd12, OP_ASR  = 4'd13, OP_R14 = 4'd14, OP_R15  = 4'd15
  } op_e;

  state_e             state_q, state_d;
  op_e                sh_op_q, sh_op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d, sh_q, sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_q, c_d, n_q, n_d, z_q, z_d, v_q, v_d, done_q, done_d;

  logic               commit, c_new, v_new, cin, c_into_msb, sh_bit;
  logic [WIDTH-1:0]   res_new, b_x, sh_next;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    sh_op_d  = sh_op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sh_d     = sh_q;
    result_d = result_q;
    c_d      = c_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    done_d   = 1'b0;
    commit   = 1'b0;
    res_new  = a;
    c_new    = 1'b0;
    v_new    = 1'b0;

    // SUB/SBC add the inverted operand; ADC/SBC chain in the current carry flag.
    b_x = (op == OP_SUB || op == OP_SBC) ? ~b : b;
    case (op)
      OP_SUB:         cin = 1'b1;
      OP_ADC, OP_SBC: cin = c_q;
      default:        cin = 1'b0;
    endcase
    sum        = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};
    c_into_msb = a[WIDTH-1] ^ b_x[WIDTH-1] ^ sum[WIDTH-1];

    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (sh_op_q)
      OP_LSL: begin
        sh_next = {sh_q[WIDTH-2:0], 1'b0};
        sh_bit  = sh_q[WIDTH-1];
      end
      OP_LSR: begin
        sh_next = {1'b0, sh_q[WIDTH-1:1]};
        sh_bit  = sh_q[0];
      end
      default: begin
        sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        sh_bit  = sh_q[0];
      end
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_NOTA: begin commit = 1'b1; res_new = ~a;       end
            OP_NOTB: begin commit = 1'b1; res_new = ~b;       end
            OP_AND:  begin commit = 1'b1; res_new = a & b;    end
            OP_OR:   begin commit = 1'b1; res_new = a | b;    end
            OP_XOR:  begin commit = 1'b1; res_new = a ^ b;    end
            OP_XNOR: begin commit = 1'b1; res_new = ~(a ^ b); end
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
              commit  = 1'b1;
              res_new = sum[WIDTH-1:0];
              c_new   = sum[WIDTH];
              v_new   = c_into_msb ^ sum[WIDTH];
            end
            OP_MUL: begin
              state_d  = ST_MUL;
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, a};
              mplier_d = b;
              cnt_d    = CW'(WIDTH);
            end
            OP_LSL, OP_LSR, OP_ASR: begin
              if (b[SHW-1:0] == '0) begin
                commit = 1'b1;
              end else begin
                state_d = ST_SHF;
                sh_d    = a;
                sh_op_d = op_e'(op);
                cnt_d   = {1'b0, b[SHW-1:0]};
              end
            end
            default: commit = 1'b1;
          endcase
        end
      end
      ST_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          commit  = 1'b1;
          res_new = acc_next[WIDTH-1:0];
          c_new   = |acc_next[2*WIDTH-1:WIDTH];
        end
      end
      ST_SHF: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          commit  = 1'b1;
          res_new = sh_next;
          c_new   = sh_bit;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      result_d = res_new;
      c_d      = c_new;
      v_d      = v_new;
      n_d      = res_new[WIDTH-1];
      z_d      = (res_new == '0);
      done_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sh_op_q  <= OP_LSL;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sh_q     <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_op_q  <= sh_op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      c_q      <= c_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign c      = c_q;
  assign n      = n_q;
  assign z      = z_q;
  assign v      = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed plan steps plus random ops
// compared against an integer-arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c, n, z, v;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  int c_model = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c(c), .n(n), .z(z), .v(v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference: result/carry/overflow from plain integer arithmetic, plus busy cycles.
  function automatic void model(input int o, input int av, input int bv, input int cin,
                                output int res, output int cf, output int vf, output int cyc);
    int full, s, sh, sa, sb;
    sa = sx(av); sb = sx(bv);
    res = av; cf = 0; vf = 0; cyc = 0; s = 0; full = 0;
    sh = bv & (W - 1);
    case (o)
      0: res = ~av & 255;
      1: res = ~bv & 255;
      2: res = av & bv;
      3: res = av | bv;
      4: res = av ^ bv;
      5: res = ~(av ^ bv) & 255;
      6: begin full = av + bv;               s = sa + sb;           end
      7: begin full = av + (255 - bv) + 1;   s = sa - sb;           end
      8: begin full = av + bv + cin;         s = sa + sb + cin;     end
      9: begin full = av + (255 - bv) + cin; s = sa - sb - 1 + cin; end
      10: begin
        full = av * bv; res = full & 255; cf = ((full >> 8) != 0) ? 1 : 0; cyc = W;
      end
      11: begin
        res = (av << sh) & 255; cf = (sh > 0) ? (av >> (W - sh)) & 1 : 0; cyc = sh;
      end
      12: begin
        res = av >> sh; cf = (sh > 0) ? (av >> (sh - 1)) & 1 : 0; cyc = sh;
      end
      13: begin
        res = (sa >>> sh) & 255; cf = (sh > 0) ? (sa >>> (sh - 1)) & 1 : 0; cyc = sh;
      end
      default: res = av;
    endcase
    if (o >= 6 && o <= 9) begin
      res = full & 255;
      cf  = (full >> 8) & 1;
      vf  = (s > 127 || s < -128) ? 1 : 0;
    end
  endfunction

  // Issue one request, optionally poke start while busy, and check everything at done.
  task automatic do_op(input int o, input int av, input int bv, input string tag,
                       input int poke = -1);
    int er, ec, ev, ecyc, busy_cnt;
    bit seen;
    model(o, av, bv, c_model, er, ec, ev, ecyc);
    @(negedge clk);
    start = 1'b1; op = o[3:0]; a = av[W-1:0]; b = bv[W-1:0];
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    busy_cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done === 1'b1) seen = 1;
      else begin
        if (busy === 1'b1) busy_cnt++;
        if (busy_cnt == poke) begin start = 1'b1; op = 4'd6; end
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check({tag, "/done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "/result"}, 32'(result), 32'(er));
      check({tag, "/c"}, 32'(c), 32'(ec));
      check({tag, "/v"}, 32'(v), 32'(ev));
      check({tag, "/n"}, 32'(n), 32'((er >> 7) & 1));
      check({tag, "/z"}, 32'(z), 32'(er == 0));
      check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(ecyc));
    end
    c_model = ec;
  endtask

  task automatic idle_check(input string tag, input int exp_res);
    @(posedge clk); #1;
    check({tag, "/done_low"}, 32'(done), 32'd0);
    check({tag, "/busy_low"}, 32'(busy), 32'd0);
    check({tag, "/held"}, 32'(result), 32'(exp_res));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/busy"}, 32'(busy), 32'd0);
    check({tag, "/done"}, 32'(done), 32'd0);
    check({tag, "/result"}, 32'(result), 32'd0);
    check({tag, "/flags"}, {28'd0, c, n, z, v}, 32'd0);
  endtask

  initial begin
    int dones;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    // Plan 1-3: arithmetic flags and the carry chain.
    do_op(6, 8'h7F, 8'h01, "add_ovf");
    idle_check("add_ovf_idle", 8'h80);
    do_op(7, 8'h05, 8'h05, "sub_zero");
    do_op(7, 8'h00, 8'h01, "sub_borrow");
    do_op(6, 8'hFF, 8'h01, "add_carry");
    do_op(8, 8'h00, 8'h00, "adc_chain");
    do_op(9, 8'h10, 8'h01, "sbc_chain");

    // Plan 4: multiplier with an ignored start mid-operation.
    do_op(10, 8'h10, 8'h11, "mul", 4);
    idle_check("mul_no_extra_done", 8'h10);

    // Plan 5: shifts.
    do_op(13, 8'h80, 8'h03, "asr3");
    do_op(12, 8'h81, 8'h01, "lsr1");
    do_op(11, 8'h81, 8'h00, "lsl0");
    do_op(11, 8'h81, 8'hF9, "lsl_upper_b_ignored");
    do_op(14, 8'h5A, 8'h33, "reserved14");

    // Plan 6: asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 4'd10; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    c_model = 0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("reset_no_done", 32'(dones), 32'd0);
    check("reset_idle_busy", 32'(busy), 32'd0);
    do_op(6, 8'h02, 8'h03, "add_after_reset");

    // Random ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
